// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
// Provides the stall vector width, the stall patterns for each requesting
// stage and the state encoding of the multi-cycle EX timer.
// Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
package pipe_ctrl_pkg;

  localparam int CTRL_WIDTH   = 6;
  localparam int EX_CNT_WIDTH = 6;
  localparam int PC_WIDTH     = 32;
  localparam int PERF_WIDTH   = 32;

  // Each pattern stalls the requesting stage and everything upstream of it;
  // the first zero bit above the requester turns into a bubble.
  localparam logic [CTRL_WIDTH-1:0] STALL_NONE = 6'b000000;
  localparam logic [CTRL_WIDTH-1:0] STALL_IF   = 6'b000011;
  localparam logic [CTRL_WIDTH-1:0] STALL_ID   = 6'b000111;
  localparam logic [CTRL_WIDTH-1:0] STALL_EX   = 6'b001111;
  localparam logic [CTRL_WIDTH-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline stages and the sequencer.
// master: stage side, drives stall requests / multi-cycle start / exception
//         and receives the stall vector, flush/redirect, timer status, perf.
// slave : sequencer side (pipe_ctrl), the mirror image.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_WIDTH   = pipe_ctrl_pkg::CTRL_WIDTH,
  parameter int EX_CNT_WIDTH = pipe_ctrl_pkg::EX_CNT_WIDTH,
  parameter int PC_WIDTH     = pipe_ctrl_pkg::PC_WIDTH,
  parameter int PERF_WIDTH   = pipe_ctrl_pkg::PERF_WIDTH
);

  logic                    stallreq_if;
  logic                    stallreq_id;
  logic                    stallreq_mem;
  logic                    ex_mc_start;
  logic [EX_CNT_WIDTH-1:0] ex_mc_cycles;
  logic                    exc_valid;
  logic [PC_WIDTH-1:0]     exc_target;
  logic [CTRL_WIDTH-1:0]   stall;
  logic                    flush;
  logic [PC_WIDTH-1:0]     new_pc;
  logic                    ex_busy;
  logic                    ex_done;
  logic [PERF_WIDTH-1:0]   perf_stall_cycles;
  logic [PERF_WIDTH-1:0]   perf_flush_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem,
    output ex_mc_start, ex_mc_cycles, exc_valid, exc_target,
    input  stall, flush, new_pc, ex_busy, ex_done,
    input  perf_stall_cycles, perf_flush_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem,
    input  ex_mc_start, ex_mc_cycles, exc_valid, exc_target,
    output stall, flush, new_pc, ex_busy, ex_done,
    output perf_stall_cycles, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_mc_timer.sv
// pipe_mc_timer: IDLE/BUSY/DONE countdown for multi-cycle EX ops (DIV/MADD).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       EX begins a multi-cycle op (honoured only in IDLE)
//   cycles      op length K, sampled with start
//   hold        stall[3]: EX/MEM not capturing, keep result in DONE
//   kill        exception/ERET: abandon the op, back to IDLE
//   busy_stall  combinational EX stall request (start cycle and BUSY)
//   busy, done  registered state flags
module pipe_mc_timer #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cycles,
  input  logic                 hold,
  input  logic                 kill,
  output logic                 busy_stall,
  output logic                 busy,
  output logic                 done
);
  import pipe_ctrl_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  mc_state_e            state_r, state_s, nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s, nxt_cnt_s;
  logic                 busy_r, done_r;

  // EX stall request: kept apart from next-state logic so that hold, which
  // is derived from this request, never loops back into it.
  always_comb begin
    busy_stall = 1'b0;
    case (state_r)
      MC_IDLE: busy_stall = start && (cycles != CNT_ZERO);
      MC_BUSY: busy_stall = 1'b1;
      MC_DONE: busy_stall = 1'b0;
      default: busy_stall = 1'b0;
    endcase
  end

  // Next state and counter; kill overrides everything including a start.
  always_comb begin
    nxt_s     = state_r;
    nxt_cnt_s = cnt_r;
    case (state_r)
      MC_IDLE: begin
        if (start && (cycles == CNT_ONE)) begin
          nxt_s = MC_DONE;
        end else if (start && (cycles != CNT_ZERO)) begin
          nxt_s     = MC_BUSY;
          nxt_cnt_s = cycles - CNT_ONE;
        end else begin
          nxt_s = MC_IDLE;
        end
      end
      MC_BUSY: begin
        // Counting ignores hold: a MEM stall overlaps the remaining cycles.
        if (cnt_r == CNT_ONE) begin
          nxt_s     = MC_DONE;
          nxt_cnt_s = CNT_ZERO;
        end else begin
          nxt_cnt_s = cnt_r - CNT_ONE;
        end
      end
      MC_DONE: begin
        // Leave only when EX/MEM actually captures the result.
        if (hold) begin
          nxt_s = MC_DONE;
        end else begin
          nxt_s = MC_IDLE;
        end
      end
      default: begin
        nxt_s     = MC_IDLE;
        nxt_cnt_s = CNT_ZERO;
      end
    endcase
    state_s = kill ? MC_IDLE  : nxt_s;
    cnt_s   = kill ? CNT_ZERO : nxt_cnt_s;
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= MC_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == MC_BUSY);
      done_r  <= (state_s == MC_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the five-stage MIPS core.
// Picks the deepest stall request (exception > MEM > EX > ID > IF), drives
// the stall vector, flush and redirect PC, and hosts the multi-cycle EX timer.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   bus         pipe_ctrl_if.slave: stall requests, ex_mc_start/cycles,
//               exc_valid/target in; stall, flush, new_pc, ex_busy, ex_done,
//               perf_stall_cycles, perf_flush_cnt out
// Build option: define PIPE_CTRL_PERF_EN to build the performance counters;
// otherwise the perf outputs read zero and no counter flops exist.
module pipe_ctrl #(
  parameter int CTRL_WIDTH   = pipe_ctrl_pkg::CTRL_WIDTH,
  parameter int EX_CNT_WIDTH = pipe_ctrl_pkg::EX_CNT_WIDTH,
  parameter int PC_WIDTH     = pipe_ctrl_pkg::PC_WIDTH,
  parameter int PERF_WIDTH   = pipe_ctrl_pkg::PERF_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);
  import pipe_ctrl_pkg::*;

  logic [CTRL_WIDTH-1:0] stall_s;
  logic                  flush_s;
  logic [PC_WIDTH-1:0]   new_pc_s;
  logic                  ex_stall_s;
  logic                  ex_busy_s;
  logic                  ex_done_s;

  pipe_mc_timer #(
    .CNT_WIDTH (EX_CNT_WIDTH)
  ) u_mc_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bus.ex_mc_start),
    .cycles     (bus.ex_mc_cycles),
    .hold       (stall_s[3]),
    .kill       (bus.exc_valid),
    .busy_stall (ex_stall_s),
    .busy       (ex_busy_s),
    .done       (ex_done_s)
  );

  // Priority mux: the deepest requester alone sets the stall pattern.
  always_comb begin
    stall_s  = STALL_NONE;
    flush_s  = 1'b0;
    new_pc_s = {PC_WIDTH{1'b0}};
    if (bus.exc_valid) begin
      flush_s  = 1'b1;
      new_pc_s = bus.exc_target;
    end else if (bus.stallreq_mem) begin
      stall_s = STALL_MEM;
    end else if (ex_stall_s) begin
      stall_s = STALL_EX;
    end else if (bus.stallreq_id) begin
      stall_s = STALL_ID;
    end else if (bus.stallreq_if) begin
      stall_s = STALL_IF;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  assign bus.stall   = stall_s;
  assign bus.flush   = flush_s;
  assign bus.new_pc  = new_pc_s;
  assign bus.ex_busy = ex_busy_s;
  assign bus.ex_done = ex_done_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] perf_stall_r;
  logic [PERF_WIDTH-1:0] perf_flush_r;

  // Free-running event counters, wrapping naturally at 2^PERF_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_r <= {PERF_WIDTH{1'b0}};
      perf_flush_r <= {PERF_WIDTH{1'b0}};
    end else begin
      if (stall_s[0]) begin
        perf_stall_r <= perf_stall_r + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
      end
      if (flush_s) begin
        perf_flush_r <= perf_flush_r + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.perf_stall_cycles = perf_stall_r;
  assign bus.perf_flush_cnt    = perf_flush_r;
`else
  assign bus.perf_stall_cycles = {PERF_WIDTH{1'b0}};
  assign bus.perf_flush_cnt    = {PERF_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
// The driver applies one vector per cycle just after the rising edge and
// queues the hand-computed response; the monitor pops and compares on the
// falling edge of the same cycle.
module tb_pipe_ctrl;

  logic clk;
  logic rst_n;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        chk_stall;
    logic        chk_perf;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Modifiers applied to the next vector(s).
  logic        rst_v     = 1'b1;
  logic        chk_stall = 1'b1;
  logic        chk_perf  = 1'b0;
  logic [31:0] exp_ps    = 32'd0;
  logic [31:0] exp_pf    = 32'd0;

  task automatic cyc(input logic r_if, input logic r_id, input logic r_mem,
                     input logic st, input logic [5:0] k,
                     input logic ex, input logic [31:0] tgt,
                     input logic [5:0] e_stall, input logic e_flush,
                     input logic [31:0] e_pc, input logic e_busy,
                     input logic e_done, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst_v;
    bus.stallreq_if  = r_if;
    bus.stallreq_id  = r_id;
    bus.stallreq_mem = r_mem;
    bus.ex_mc_start  = st;
    bus.ex_mc_cycles = k;
    bus.exc_valid    = ex;
    bus.exc_target   = tgt;
    e.stall     = e_stall;
    e.flush     = e_flush;
    e.pc        = e_pc;
    e.busy      = e_busy;
    e.done      = e_done;
    e.chk_stall = chk_stall;
    e.chk_perf  = chk_perf;
    e.ps        = exp_ps;
    e.pf        = exp_pf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: one comparison per queued cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      logic  ok;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      ok = (bus.flush === e.flush) && (bus.new_pc === e.pc) &&
           (bus.ex_busy === e.busy) && (bus.ex_done === e.done);
      if (e.chk_stall) ok = ok && (bus.stall === e.stall);
      if (e.chk_perf)
        ok = ok && (bus.perf_stall_cycles === e.ps) && (bus.perf_flush_cnt === e.pf);
      n_tests = n_tests + 1;
      if (!ok) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b done=%b ps=%0d pf=%0d; want stall=%b flush=%b pc=%h busy=%b done=%b ps=%0d pf=%0d",
                 t, bus.stall, bus.flush, bus.new_pc, bus.ex_busy, bus.ex_done,
                 bus.perf_stall_cycles, bus.perf_flush_cnt,
                 e.stall, e.flush, e.pc, e.busy, e.done, e.ps, e.pf);
      end
    end
  end

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] EV = 32'hBFC00380;

  initial begin
    rst_n            = 1'b0;
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.ex_mc_start  = 1'b0;
    bus.ex_mc_cycles = 6'd0;
    bus.exc_valid    = 1'b0;
    bus.exc_target   = 32'h0;
    repeat (3) @(posedge clk);

    // Reset state, then single requests and priority.
    //  if id mem st k     ex tgt  stall       fl pc busy done
    chk_perf = 1'b1;
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "reset");
    chk_perf = 1'b0;
    cyc(1, 0, 0, 0, 6'd0, 0, Z, 6'b000011, 0, Z, 0, 0, "req_if");
    cyc(0, 1, 0, 0, 6'd0, 0, Z, 6'b000111, 0, Z, 0, 0, "req_id");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 0, "req_mem");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "req_none");
    cyc(1, 1, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 0, "prio_all");
    cyc(1, 1, 0, 0, 6'd0, 0, Z, 6'b000111, 0, Z, 0, 0, "prio_if_id");

    // K=4: EX stall for 4 cycles, done on the 5th, idle on the 6th.
    cyc(0, 0, 0, 1, 6'd4, 0, Z, 6'b001111, 0, Z, 0, 0, "k4_n");
    cyc(0, 1, 0, 0, 6'd0, 0, Z, 6'b001111, 0, Z, 1, 0, "k4_n1_id");
    cyc(0, 0, 0, 1, 6'd1, 0, Z, 6'b001111, 0, Z, 1, 0, "k4_n2_restart");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b001111, 0, Z, 1, 0, "k4_n3");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 1, "k4_done");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "k4_idle");

    // K=0 is ignored; K=1 stalls once.
    cyc(0, 0, 0, 1, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "k0_start");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "k0_after");
    cyc(0, 0, 0, 1, 6'd1, 0, Z, 6'b001111, 0, Z, 0, 0, "k1_start");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 1, "k1_done");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "k1_idle");

    // K=2 at cycle 5 with MEM stall 6..9: done held 7..10, idle at 11.
    cyc(0, 0, 0, 1, 6'd2, 0, Z, 6'b001111, 0, Z, 0, 0, "k2m_c5");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 1, 0, "k2m_c6");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 1, "k2m_c7");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 1, "k2m_c8");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 1, "k2m_c9");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 1, "k2m_c10");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "k2m_c11");

    // Exception at cycle 3 of a K=8 op.
    cyc(0, 0, 0, 1, 6'd8, 0, Z,  6'b001111, 0, Z,  0, 0, "exc_c0");
    cyc(0, 0, 0, 0, 6'd0, 0, Z,  6'b001111, 0, Z,  1, 0, "exc_c1");
    cyc(0, 0, 0, 0, 6'd0, 0, Z,  6'b001111, 0, Z,  1, 0, "exc_c2");
    cyc(0, 0, 0, 0, 6'd0, 1, EV, 6'b000000, 1, EV, 1, 0, "exc_c3");
    cyc(0, 0, 0, 0, 6'd0, 0, Z,  6'b000000, 0, Z,  0, 0, "exc_c4");

    // Exception beats same-cycle start and a MEM request.
    cyc(0, 0, 1, 1, 6'd3, 1, 32'h8000_0180, 6'b000000, 1, 32'h8000_0180, 0, 0, "exc_vs_start");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "exc_vs_after");

    // Reset while BUSY.
    cyc(0, 0, 0, 1, 6'd5, 0, Z, 6'b001111, 0, Z, 0, 0, "rst_start");
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b001111, 0, Z, 1, 0, "rst_busy");
    rst_v = 1'b0; chk_stall = 1'b0;
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 1, 0, "rst_cycle");
    rst_v = 1'b1; chk_stall = 1'b1; chk_perf = 1'b1;
    exp_ps = 32'd0; exp_pf = 32'd0;
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "rst_after");
    chk_perf = 1'b0;

    // Perf: 7 stall cycles and 2 flushes counted from reset.
    cyc(1, 0, 0, 0, 6'd0, 0, Z, 6'b000011, 0, Z, 0, 0, "perf_s1");
    cyc(1, 0, 0, 0, 6'd0, 0, Z, 6'b000011, 0, Z, 0, 0, "perf_s2");
    cyc(1, 0, 0, 0, 6'd0, 0, Z, 6'b000011, 0, Z, 0, 0, "perf_s3");
    cyc(0, 1, 0, 0, 6'd0, 0, Z, 6'b000111, 0, Z, 0, 0, "perf_s4");
    cyc(0, 1, 0, 0, 6'd0, 0, Z, 6'b000111, 0, Z, 0, 0, "perf_s5");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 0, "perf_s6");
    cyc(0, 0, 1, 0, 6'd0, 0, Z, 6'b011111, 0, Z, 0, 0, "perf_s7");
    cyc(0, 0, 0, 0, 6'd0, 1, EV, 6'b000000, 1, EV, 0, 0, "perf_f1");
    cyc(0, 0, 0, 0, 6'd0, 1, EV, 6'b000000, 1, EV, 0, 0, "perf_f2");
    chk_perf = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
    exp_ps = 32'd7; exp_pf = 32'd2;
`else
    exp_ps = 32'd0; exp_pf = 32'd0;
`endif
    cyc(0, 0, 0, 0, 6'd0, 0, Z, 6'b000000, 0, Z, 0, 0, "perf_check");
    chk_perf = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage MIPS core. Collects stall requests from IF, ID, EX and MEM, owns the multi-cycle EX countdown (DIV/MADD), and drives the shared `stall[5:0]` vector to the PC and every pipeline register (IF/ID through MEM/WB). It also issues the exception flush and redirect PC. Every stage register applies one rule: `stall[n]=1 && stall[n+1]=0` inserts a bubble, `stall[n]=1 && stall[n+1]=1` holds, and `stall[n]=0` advances.

## Interface
Parameters:
- CTRL_WIDTH, 6, stall vector width: bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- EX_CNT_WIDTH, 6, width of the multi-cycle length field.
- PC_WIDTH, 32, redirect address width.
- PERF_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- stallreq_if  in  1  fetch wait.
- stallreq_id  in  1  load-use hazard.
- stallreq_mem  in  1  data bus wait.
- ex_mc_start  in  1  EX begins a multi-cycle op.
- ex_mc_cycles  in  EX_CNT_WIDTH  op length K in cycles, sampled with start.
- exc_valid  in  1  exception or ERET committed in MEM.
- exc_target  in  PC_WIDTH  handler or EPC address.
- stall  out  CTRL_WIDTH  stall vector.
- flush  out  1  kill all stage registers.
- new_pc  out  PC_WIDTH  redirect PC, valid with flush.
- ex_busy  out  1  countdown in progress.
- ex_done  out  1  EX result ready to leave EX.
- perf_stall_cycles  out  PERF_WIDTH  count of cycles with stall[0]=1.
- perf_flush_cnt  out  PERF_WIDTH  count of flush events.

## Operation
- Stall vector is combinational. Only the deepest requesting stage counts, in priority order:
  - exc_valid: stall=000000, flush=1, new_pc=exc_target.
  - MEM: 011111.
  - EX (ex_mc_start with K≠0 in IDLE, or state BUSY): 001111.
  - ID: 000111.
  - IF: 000011.
  - No request: 000000.
- flush=0 gives new_pc=0.
- Timer FSM states: IDLE, BUSY, DONE. It uses a down-counter `cnt` of EX_CNT_WIDTH bits.
- IDLE:
  - start with K=0: ignored, no stall.
  - start with K=1: go to DONE.
  - start with K≥2: go to BUSY and load cnt=K-1.
  - EX stall is asserted in the start cycle whenever K≥1.
- BUSY:
  - EX stall is asserted.
  - cnt=1: go to DONE.
  - Otherwise: decrement cnt.
  - Counting continues even while MEM stalls.
- DONE:
  - ex_done=1 and EX stall is released.
  - Stays in DONE while stall[3]=1 (MEM still stalled).
  - Goes to IDLE on the first cycle with stall[3]=0, when EX/MEM captures the result.
- ex_mc_start outside IDLE is ignored.
- ex_busy=(state==BUSY). ex_done=(state==DONE).
- exc_valid in any state forces IDLE and cnt=0 on the next edge. It overrides a same-cycle ex_mc_start.

## Timing
- Reset values: state IDLE, cnt 0, ex_busy 0, ex_done 0, flush 0, new_pc 0, perf counters 0.
- stall is 0 during reset unless inputs request otherwise. Request inputs are expected low during reset.
- Start at cycle N with length K: EX stall in cycles N..N+K-1 (exactly K cycles). ex_done=1 from cycle N+K. Back in IDLE at N+K+1 when there is no MEM stall.
- Reset mid-operation: the next edge returns to IDLE regardless of state.
- Zero-cycle path: request to stall has no registers.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cycles increments each cycle with stall[0]=1.
  - perf_flush_cnt increments each cycle with flush=1.
  - Both wrap modulo 2^PERF_WIDTH and clear on reset.
- PIPE_CTRL_PERF_EN undefined: the ports remain but are tied to 0, and no counter flops are built.

## Structure
- Shared defines/package:
  - CTRL_WIDTH.
  - Stall pattern constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - FSM state encodings.
- Sub-module pipe_mc_timer holds the IDLE/BUSY/DONE FSM and cnt.
  - Inputs: start, cycles, hold (stall[3]), kill (exc_valid).
  - Outputs: busy_stall, busy, done.
- pipe_ctrl holds the priority mux and the optional perf counters.

## Test plan
- Single requests, one per cycle, in order stallreq_if, id, mem → stall = 000011, 000111, 011111. With no request → 000000.
- ex_mc_start with K=4 at cycle 10 → stall=001111 in cycles 10–13. ex_done=1 in cycle 14, stall=000000 in 14, IDLE at 15. K=0 → no stall.
- K=2 at cycle 5 plus stallreq_mem held for cycles 6–9 → stall=011111 in 6–9. ex_done=1 from 7 through 10. IDLE at 11.
- exc_valid with exc_target=0xBFC00380 at cycle 3 of a K=8 op → flush=1, new_pc=0xBFC00380, stall=000000 in that cycle. Next cycle ex_busy=0 and ex_done=0.
- Reset asserted in BUSY → next cycle state IDLE, all outputs at reset values.
- Built with PIPE_CTRL_PERF_EN: 7 stall cycles and 2 flushes → perf_stall_cycles=7, perf_flush_cnt=2. Built without it → both read 0.
